// File: rtl/riscv_opfetch_pkg.sv
// Shared definitions for the operand-fetch stage: datapath width, register-index type, x0.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_opfetch_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    // A writer only supplies a value when it really writes a non-x0 register the reader wants.
    function automatic logic src_match(input logic wen, input reg_idx_t rd, input reg_idx_t addr);
        return wen && (rd == addr) && (addr != X0);
    endfunction

endpackage

// File: rtl/riscv_opfetch_fwd_mux.sv
// Per-operand bypass select: youngest pending writer wins, x0 always reads zero.
// Purely combinational; an EX-stage load never forwards (its data is not ready yet).
module riscv_fwd_mux
    import riscv_opfetch_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              ex_wen_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_data_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              wb_wen_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   data_o
);

    always_comb begin
        data_o = rf_data_i;
        if (addr_i == X0) begin
            data_o = '0;
        end else if (src_match(ex_wen_i && !ex_is_load_i, ex_rd_i, addr_i)) begin
            data_o = ex_data_i;
        end else if (src_match(mem_wen_i, mem_rd_i, addr_i)) begin
            data_o = mem_data_i;
        end else if (src_match(wb_wen_i, wb_rd_i, addr_i)) begin
            // Regfile write lands at the edge, so the same-cycle read still sees the old value.
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/riscv_opfetch.sv
// Operand fetch: regfile addressing, EX/MEM/WB bypass, load-use bubble, ID/EX register.
// One cycle from acceptance to o_ex_valid; holds bit-stable while EX is not ready.
module riscv_opfetch
    import riscv_opfetch_pkg::*;
#(
    parameter int XLEN        = `XLEN,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [REG_AW-1:0]      i_id_rs1_addr,
    input  logic [REG_AW-1:0]      i_id_rs2_addr,
    input  logic                   i_id_rs1_used,
    input  logic                   i_id_rs2_used,
    input  logic [REG_AW-1:0]      i_id_rd_addr,
    output logic [REG_AW-1:0]      o_regfile_rs1_addr,
    output logic [REG_AW-1:0]      o_regfile_rs2_addr,
    input  logic [XLEN-1:0]        i_regfile_rs1_data,
    input  logic [XLEN-1:0]        i_regfile_rs2_data,
    input  logic                   i_ex_wen,
    input  logic                   i_ex_is_load,
    input  logic [REG_AW-1:0]      i_ex_rd_addr,
    input  logic [XLEN-1:0]        i_ex_data,
    input  logic                   i_mem_wen,
    input  logic [REG_AW-1:0]      i_mem_rd_addr,
    input  logic [XLEN-1:0]        i_mem_data,
    input  logic                   i_wb_wen,
    input  logic [REG_AW-1:0]      i_wb_rd_addr,
    input  logic [XLEN-1:0]        i_wb_data,
    input  logic                   i_flush,
    output logic                   o_ex_valid,
    input  logic                   i_ex_ready,
    output logic [XLEN-1:0]        o_ex_rs1_data,
    output logic [XLEN-1:0]        o_ex_rs2_data,
    output logic [REG_AW-1:0]      o_ex_rd_addr,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    logic                   ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]        rs1_q, rs1_d;
    logic [XLEN-1:0]        rs2_q, rs2_d;
    logic [REG_AW-1:0]      rd_q, rd_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic            adv;
    logic            ex_load_wr;
    logic            hazard;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign o_regfile_rs1_addr = i_id_rs1_addr;
    assign o_regfile_rs2_addr = i_id_rs2_addr;

    assign adv        = !ex_valid_q || i_ex_ready;
    assign ex_load_wr = i_ex_wen && i_ex_is_load && (i_ex_rd_addr != X0);
    assign hazard     = ex_load_wr &&
                        ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                         (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));
    assign o_id_ready = adv && !hazard && !i_flush;

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr_i       (i_id_rs1_addr),
        .rf_data_i    (i_regfile_rs1_data),
        .ex_wen_i     (i_ex_wen),
        .ex_is_load_i (i_ex_is_load),
        .ex_rd_i      (i_ex_rd_addr),
        .ex_data_i    (i_ex_data),
        .mem_wen_i    (i_mem_wen),
        .mem_rd_i     (i_mem_rd_addr),
        .mem_data_i   (i_mem_data),
        .wb_wen_i     (i_wb_wen),
        .wb_rd_i      (i_wb_rd_addr),
        .wb_data_i    (i_wb_data),
        .data_o       (fwd_rs1)
    );

    riscv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr_i       (i_id_rs2_addr),
        .rf_data_i    (i_regfile_rs2_data),
        .ex_wen_i     (i_ex_wen),
        .ex_is_load_i (i_ex_is_load),
        .ex_rd_i      (i_ex_rd_addr),
        .ex_data_i    (i_ex_data),
        .mem_wen_i    (i_mem_wen),
        .mem_rd_i     (i_mem_rd_addr),
        .mem_data_i   (i_mem_data),
        .wb_wen_i     (i_wb_wen),
        .wb_rd_i      (i_wb_rd_addr),
        .wb_data_i    (i_wb_data),
        .data_o       (fwd_rs2)
    );

    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            if (i_id_valid && !hazard) begin
                ex_valid_d = 1'b1;
                rs1_d      = fwd_rs1;
                rs2_d      = fwd_rs2;
                rd_d       = i_id_rd_addr;
            end else begin
                ex_valid_d = 1'b0;
            end
            // Only real load-use bubbles are counted, never idle slots.
            if (i_id_valid && hazard && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_rs1_data = rs1_q;
    assign o_ex_rs2_data = rs2_q;
    assign o_ex_rd_addr  = rd_q;
    assign o_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_riscv_opfetch.sv
// Scoreboard bench for riscv_opfetch: driver predicts each accepted operand pair, monitor checks it at handoff.
module tb_riscv_opfetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, id_ready;
    logic [4:0]  rs1, rs2, id_rd;
    logic        rs1_used, rs2_used;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_d1, rf_d2;
    logic        ex_wen, ex_is_load, mem_wen, wb_wen;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        flush, ex_valid, ex_ready;
    logic [31:0] out_rs1, out_rs2;
    logic [4:0]  out_rd;
    logic [15:0] stall_cnt;

    logic [31:0] rf_mem [32];
    assign rf_d1 = rf_mem[rf_a1];
    assign rf_d2 = rf_mem[rf_a2];

    riscv_opfetch #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(id_rd),
        .o_regfile_rs1_addr(rf_a1), .o_regfile_rs2_addr(rf_a2),
        .i_regfile_rs1_data(rf_d1), .i_regfile_rs2_data(rf_d2),
        .i_ex_wen(ex_wen), .i_ex_is_load(ex_is_load), .i_ex_rd_addr(ex_rd), .i_ex_data(ex_data),
        .i_mem_wen(mem_wen), .i_mem_rd_addr(mem_rd), .i_mem_data(mem_data),
        .i_wb_wen(wb_wen), .i_wb_rd_addr(wb_rd), .i_wb_data(wb_data),
        .i_flush(flush),
        .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_rs1_data(out_rs1), .o_ex_rs2_data(out_rs2), .o_ex_rd_addr(out_rd),
        .o_stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_cnt = '0;
    bit          known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Value a reader should observe: the youngest in-flight writer of that register, else the file.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        bit          w [3];
        logic [4:0]  r [3];
        logic [31:0] d [3];
        if (a == 5'd0) return 32'd0;
        w[0] = ex_wen && !ex_is_load; r[0] = ex_rd;  d[0] = ex_data;
        w[1] = mem_wen;               r[1] = mem_rd; d[1] = mem_data;
        w[2] = wb_wen;                r[2] = wb_rd;  d[2] = wb_data;
        for (int s = 0; s < 3; s++)
            if (w[s] && r[s] == a) return d[s];
        return rf_mem[a];
    endfunction

    function automatic bit model_hazard();
        if (!(ex_wen && ex_is_load) || ex_rd == 5'd0) return 1'b0;
        return (rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd);
    endfunction

    task automatic tick(input bit use_exp = 1'b0, input logic [31:0] e1 = '0, input logic [31:0] e2 = '0);
        bit   full, adv, haz, acc;
        exp_t e;
        #1;
        full = (sb.size() != 0);
        adv  = !full || ex_ready;
        haz  = model_hazard();
        acc  = !rst && !flush && adv && id_valid && !haz;
        if (known) begin
            chk("ex_valid", 32'(ex_valid), 32'(full));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
        if (known || flush)
            chk("id_ready", 32'(id_ready), 32'(adv && !haz && !flush));
        chk("rf_addr", {22'd0, rf_a2, rf_a1}, {22'd0, rs2, rs1});
        if (rst) begin
            sb.delete();
            m_cnt = '0;
        end else if (acc) begin
            e.rs1 = use_exp ? e1 : model_read(rs1);
            e.rs2 = use_exp ? e2 : model_read(rs2);
            e.rd  = id_rd;
            sb.push_back(e);
        end else if (!flush && adv && id_valid && haz && m_cnt != 16'hFFFF) begin
            m_cnt++;
        end
        @(posedge clk);
        #2;
        if (rst) begin
            known = 1'b1;
            chk("rst_valid", 32'(ex_valid), 32'd0);
            chk("rst_rs1", out_rs1, 32'd0);
            chk("rst_rs2", out_rs2, 32'd0);
            chk("rst_rd", 32'(out_rd), 32'd0);
            chk("rst_cnt", 32'(stall_cnt), 32'd0);
        end
    endtask

    // Monitor: a result leaves on valid&&ready; a flush drops a result that EX did not take.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_valid) begin
            if (ex_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got an output, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("out_rs1", out_rs1, e.rs1);
                    chk("out_rs2", out_rs2, e.rs2);
                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                end
            end else if (flush && sb.size() != 0) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic idle();
        rst = 0; id_valid = 0; flush = 0; ex_ready = 1;
        rs1 = 0; rs2 = 0; id_rd = 0; rs1_used = 0; rs2_used = 0;
        ex_wen = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_wen = 0; mem_rd = 0; mem_data = 0;
        wb_wen = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic randomize_inputs();
        id_valid   = ($urandom_range(0, 3) != 0);
        rs1        = 5'($urandom_range(0, 7));
        rs2        = 5'($urandom_range(0, 7));
        id_rd      = 5'($urandom);
        rs1_used   = 1'($urandom);
        rs2_used   = 1'($urandom);
        ex_wen     = 1'($urandom);
        ex_is_load = ($urandom_range(0, 2) == 0);
        ex_rd      = 5'($urandom_range(0, 7));
        ex_data    = $urandom;
        mem_wen    = 1'($urandom);
        mem_rd     = 5'($urandom_range(0, 7));
        mem_data   = $urandom;
        wb_wen     = 1'($urandom);
        wb_rd      = 5'($urandom_range(0, 7));
        wb_data    = $urandom;
        ex_ready   = ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) rf_mem[$urandom_range(0, 7)] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom | 32'h1;
        idle();
        @(posedge clk);
        #2;

        // Reset under random inputs; flush forces id_ready low even before state is known.
        randomize_inputs(); rst = 1; flush = 1; tick();
        randomize_inputs(); rst = 1; tick();
        idle(); tick();

        // Forwarding priority, then x0 reader and rd=0 writers.
        rf_mem[5] = 32'h44;
        id_valid = 1; rs1 = 5; rs2 = 5; rs1_used = 1; rs2_used = 1; id_rd = 5'd9;
        ex_wen = 1; ex_rd = 5; ex_data = 32'h11;
        mem_wen = 1; mem_rd = 5; mem_data = 32'h22;
        wb_wen = 1; wb_rd = 5; wb_data = 32'h33;
        tick(1'b1, 32'h11, 32'h11);
        ex_wen = 0;  tick(1'b1, 32'h22, 32'h22);
        mem_wen = 0; tick(1'b1, 32'h33, 32'h33);
        wb_wen = 0;  tick(1'b1, 32'h44, 32'h44);
        rs1 = 0; ex_wen = 1; mem_wen = 1; wb_wen = 1; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        tick(1'b1, 32'h0, 32'h44);

        // Load-use: one bubble, then the load is bypassed from MEM.
        idle(); tick();
        rf_mem[1] = 32'h1111; rf_mem[7] = 32'h7777;
        id_valid = 1; rs1 = 1; rs1_used = 1; rs2 = 7; rs2_used = 1; id_rd = 5'd3;
        ex_wen = 1; ex_is_load = 1; ex_rd = 7; ex_data = 32'hBAD0;
        #1; chk("lu_ready", 32'(id_ready), 32'd0); #(-0);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_rd = 7; mem_data = 32'hDEAD;
        tick(1'b1, 32'h1111, 32'hDEAD);
        mem_wen = 0; ex_wen = 1; ex_is_load = 1; ex_rd = 7; rs2_used = 0;
        tick(1'b1, 32'h1111, 32'h7777);
        chk("unused_cnt", 32'(stall_cnt), 32'd1);

        // Backpressure: three held cycles, then the next instruction goes straight in.
        idle(); rf_mem[2] = 32'h2222; rf_mem[3] = 32'h3333; rf_mem[4] = 32'h4444;
        id_valid = 1; rs1 = 2; rs2 = 3; id_rd = 5'd11;
        tick(1'b1, 32'h2222, 32'h3333);
        ex_ready = 0; rs1 = 4; rs2 = 5; id_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rs1", out_rs1, 32'h2222);
            chk("bp_rs2", out_rs2, 32'h3333);
            chk("bp_rd", 32'(out_rd), 32'd11);
        end
        ex_ready = 1;
        tick(1'b1, 32'h4444, 32'h44);
        idle(); tick();

        // Flush while full, blocked, with a hazard pending: entry dropped, counter untouched.
        id_valid = 1; rs1 = 2; rs2 = 3; id_rd = 5'd13;
        tick(1'b1, 32'h2222, 32'h3333);
        ex_ready = 0; flush = 1; rs2 = 7; rs2_used = 1; id_rd = 5'd14;
        ex_wen = 1; ex_is_load = 1; ex_rd = 7;
        tick();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_cnt", 32'(stall_cnt), 32'd1);
        idle(); tick();

        // Counter saturation.
        id_valid = 1; rs2 = 7; rs2_used = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 7;
        for (int i = 0; i < 65537; i++) tick();
        chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            tick();
        end

        idle();
        for (int i = 0; i < 4; i++) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_opfetch.md
Name: riscv_opfetch

Overview:
- Operand-fetch stage directly downstream of the RV32I register file.
- Drives regfile read addresses from the decoded instruction and applies EX/MEM/WB forwarding on the returned rs1/rs2 data.
- Detects load-use hazards and inserts bubbles.
- Registers operands into the ID/EX boundary using a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; taken from the shared `XLEN define.
- STALL_CNT_W, 16, width of the load-use bubble counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_id_valid  in  1  decoded instruction present.
- o_id_ready  out  1  stage accepts the instruction this cycle.
- i_id_rs1_addr, i_id_rs2_addr  in  5  source register indices.
- i_id_rs1_used, i_id_rs2_used  in  1  source actually read by the instruction.
- i_id_rd_addr  in  5  destination index, carried through.
- o_regfile_rs1_addr, o_regfile_rs2_addr  out  5  combinational copies of the i_id_rs*_addr inputs.
- i_regfile_rs1_data, i_regfile_rs2_data  in  XLEN  combinational regfile read data.
- i_ex_wen, i_ex_is_load  in  1  EX-stage write-back pending; EX-stage instruction is a load.
- i_ex_rd_addr  in  5  EX destination.
- i_ex_data  in  XLEN  EX result.
- i_mem_wen  in  1  MEM-stage write-back pending.
- i_mem_rd_addr  in  5  MEM destination.
- i_mem_data  in  XLEN  MEM result.
- i_wb_wen  in  1  WB write-back pending; same signals that drive the regfile write port.
- i_wb_rd_addr  in  5  WB destination.
- i_wb_data  in  XLEN  WB write data.
- i_flush  in  1  branch/exception flush.
- o_ex_valid  out  1  operands valid to EX.
- i_ex_ready  in  1  EX accepts.
- o_ex_rs1_data, o_ex_rs2_data  out  XLEN  resolved operands.
- o_ex_rd_addr  out  5  destination carried to EX.
- o_stall_cnt  out  STALL_CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (synchronous, i_rst high at a clock edge):
  - o_ex_valid=0; o_ex_rs1_data=0, o_ex_rs2_data=0; o_ex_rd_addr=0; o_stall_cnt=0.
  - Reset overrides flush and capture.
- Output register states:
  - EMPTY when o_ex_valid=0; FULL when o_ex_valid=1.
  - adv = !o_ex_valid || i_ex_ready.
- Hazard:
  - hazard = i_ex_wen && i_ex_is_load && i_ex_rd_addr!=0 && ((i_id_rs1_used && i_id_rs1_addr==i_ex_rd_addr) || (i_id_rs2_used && i_id_rs2_addr==i_ex_rd_addr)).
  - hazard is evaluated independently of i_id_valid.
  - o_id_ready = adv && !hazard && !i_flush (combinational).
- Forwarding, per operand, combinational, in priority order:
  1. Address 0 → 0.
  2. EX match with i_ex_wen && !i_ex_is_load → i_ex_data.
  3. MEM match with i_mem_wen → i_mem_data.
  4. WB match with i_wb_wen → i_wb_data. The regfile write is not visible in the same cycle, so WB forwarding is mandatory.
  5. Otherwise → regfile data.
- Next-state at the clock edge, in priority order:
  - i_flush: o_ex_valid←0; the ID instruction is not accepted.
  - adv && i_id_valid && !hazard: capture forwarded operands and rd; o_ex_valid←1.
  - adv && (!i_id_valid || hazard): o_ex_valid←0 (bubble).
  - !adv: hold all outputs bit-stable.
- Stall counter:
  - Increments by 1 on each edge where i_id_valid && hazard && adv && !i_flush.
  - Saturates at all-ones; no wrap.
- Latency and throughput:
  - 1 cycle from acceptance to o_ex_valid.
  - Full throughput (1 instruction/cycle) absent hazards.
  - A load-use dependency costs exactly 1 bubble: the next cycle the load sits in MEM and is forwarded.
- Boundaries:
  - Simultaneous EX/MEM/WB matches → youngest (EX) wins.
  - rd=0 writers are never forwarded.
  - Flush during hold drops the held entry.
  - Flush and hazard together → flush only; counter unchanged.
  - A hazard on an unused source is ignored.

Decomposition:
- Shared header/package: `XLEN, register-index width (5), x0 constant.
- Sub-module riscv_fwd_mux: one instance per operand.
  - Inputs: addr, regfile data, EX/MEM/WB tuples.
  - Output: resolved data.
  - Purely combinational.
- The top level holds the hazard logic, the output register, and the counter.

Test Plan:
1. Reset with i_rst=1 for 2 cycles, all inputs random → o_ex_valid=0, operands 0, o_stall_cnt=0, o_id_ready=0 while i_flush=1.
2. Forwarding priority:
   - Setup: rs1=5, rs2=5; EX writes x5=0x11, MEM x5=0x22, WB x5=0x33, regfile returns 0x44.
   - Expected sequence: operand =0x11; drop EX → 0x22; drop MEM → 0x33; drop WB → 0x44.
   - With rs1=0 → 0 regardless of writers.
3. Load-use:
   - Stimulus: EX is a load to x7; ID reads rs2=x7 (used); i_ex_ready=1.
   - Expected: o_id_ready=0; next cycle o_ex_valid=0 and o_stall_cnt=1.
   - Then with the load moved to MEM (0xDEAD) → captured rs2=0xDEAD.
   - Same stimulus with rs2_used=0 → no stall.
4. Backpressure:
   - Stimulus: i_ex_ready=0 for 3 cycles while FULL.
   - Expected: outputs bit-stable, o_id_ready=0; on release, next instruction captured the following cycle.
5. Flush:
   - Stimulus: flush while FULL with i_id_valid=1 and a hazard present.
   - Expected: o_ex_valid=0 next cycle; counter unchanged; the instruction is not accepted.
6. Counter saturation:
   - Stimulus: preload via 65537 hazard cycles with STALL_CNT_W=16.
   - Expected: o_stall_cnt holds at 0xFFFF.
